// File: rtl/cmd_pkg.sv
// Shared types and constants for the UART command dispatcher and the handlers it activates.
package cmd_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_RELEASE,
    S_NAK_WAIT,
    S_NAK_SEND
  } disp_state_t;

  localparam logic [7:0] OPC_BASE = 8'h10;
  localparam logic [7:0] NAK_BYTE = 8'hEE;

  // Handler slot map: opcode OPC_BASE + slot activates that slot.
  localparam int SLOT_REPLAY = 0;
  localparam int SLOT_STATUS = 1;
  localparam int SLOT_CONFIG = 2;
  localparam int SLOT_DEBUG  = 3;

  function automatic logic [7:0] opcode_to_index(input logic [7:0] opcode);
    return opcode - OPC_BASE;
  endfunction

endpackage

// File: rtl/tx_mux.sv
// Indexed multiplexer that hands one of N_SRC transmit requesters to a single UART
// transmitter; i_force_idle parks the output at start=0, data=0.
module tx_mux #(
  parameter int N_SRC  = 4,
  parameter int DATA_W = 8,
  parameter int SEL_W  = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
  input  logic [SEL_W-1:0]        i_sel,
  input  logic                    i_force_idle,
  input  logic [N_SRC-1:0]        i_start,
  input  logic [DATA_W*N_SRC-1:0] i_data,
  output logic                    o_start,
  output logic [DATA_W-1:0]       o_data
);

  always_comb begin
    // NOTE: defaults first so every path assigns both outputs; otherwise a latch is inferred.
    o_start = 1'b0;
    o_data  = '0;
    if (!i_force_idle) begin
      for (int i = 0; i < N_SRC; i++) begin
        if (i_sel == SEL_W'(i)) begin
          o_start = i_start[i];
          o_data  = i_data[i*DATA_W +: DATA_W];
        end
      end
    end
  end

endmodule

// File: rtl/cmd_dispatcher.sv
// UART command front end: decodes an opcode byte, hands the RX/TX path to one handler,
// and reclaims it on done or on RX inactivity; unknown opcodes are answered with a NAK byte.
module cmd_dispatcher
  import cmd_pkg::*;
#(
  parameter int N_HANDLERS     = 4,
  parameter int TIMEOUT_CYCLES = 50_000_000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    rx_ready,
  input  logic [7:0]              rx_data,
  input  logic                    tx_active,
  input  logic                    tx_done,
  output logic                    tx_start,
  output logic [7:0]              tx_data,
  output logic [N_HANDLERS-1:0]   hnd_activate,
  input  logic [N_HANDLERS-1:0]   hnd_done,
  input  logic [N_HANDLERS-1:0]   hnd_tx_start,
  input  logic [8*N_HANDLERS-1:0] hnd_tx_data,
  output logic [N_HANDLERS-1:0]   hnd_rx_ready,
  output logic                    busy,
  output logic                    timeout_err
);

  localparam int              IDX_W    = (N_HANDLERS > 1) ? $clog2(N_HANDLERS) : 1;
  localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [8:0]      N_LIMIT  = 9'(N_HANDLERS);

  disp_state_t             r_state, w_next_state;
  logic [IDX_W-1:0]        r_idx, w_next_idx;
  logic [CNT_W-1:0]        r_cnt, w_next_cnt;
  logic [N_HANDLERS-1:0]   r_activate, w_next_activate;
  logic                    r_busy;
  logic                    r_timeout_err, w_timeout_pulse;
  logic                    r_nak_start;
  logic [7:0]              r_nak_data;
  logic [7:0]              w_opc_idx;
  logic                    w_opc_valid;
  logic                    w_sel_done;
  logic                    w_cnt_expired;
  logic                    w_mux_start;
  logic [7:0]              w_mux_data;
  logic                    w_unused_tx_done;

  // tx_done runs straight from the UART to the handlers; nothing here consumes it.
  assign w_unused_tx_done = tx_done;

  assign w_opc_idx     = opcode_to_index(rx_data);
  assign w_opc_valid   = {1'b0, w_opc_idx} < N_LIMIT;
  assign w_sel_done    = hnd_done[r_idx];
  assign w_cnt_expired = (r_cnt == CNT_LAST);

  always_comb begin
    w_next_state = r_state;
    w_next_idx   = r_idx;
    case (r_state)
      S_IDLE: begin
        if (rx_ready) begin
          if (w_opc_valid) begin
            w_next_state = S_RUN;
            w_next_idx   = w_opc_idx[IDX_W-1:0];
          end else begin
            w_next_state = S_NAK_WAIT;
          end
        end
      end
      S_RUN:      if (w_sel_done || w_cnt_expired) w_next_state = S_RELEASE;
      S_RELEASE:  if (!w_sel_done && !tx_active)   w_next_state = S_IDLE;
      S_NAK_WAIT: if (!tx_active)                  w_next_state = S_NAK_SEND;
      S_NAK_SEND: w_next_state = S_IDLE;
      default:    w_next_state = S_IDLE;
    endcase
  end

  // Inactivity counter: zero on RUN entry and on every received byte. The error pulse
  // is raised on the edge the count reaches its last value, so a done seen in the
  // cycle before takes priority and suppresses it.
  always_comb begin
    w_next_cnt = '0;
    if (r_state == S_RUN && w_next_state == S_RUN && !rx_ready) begin
      w_next_cnt = r_cnt + CNT_W'(1);
    end
  end

  assign w_timeout_pulse = (r_state == S_RUN) && (w_next_state == S_RUN) &&
                           (w_next_cnt == CNT_LAST);

  always_comb begin
    w_next_activate = '0;
    for (int i = 0; i < N_HANDLERS; i++) begin
      w_next_activate[i] = (w_next_state == S_RUN) && (w_next_idx == IDX_W'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_idx         <= '0;
      r_cnt         <= '0;
      r_activate    <= '0;
      r_busy        <= 1'b0;
      r_timeout_err <= 1'b0;
      r_nak_start   <= 1'b0;
      r_nak_data    <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      r_state       <= w_next_state;
      r_idx         <= w_next_idx;
      r_cnt         <= w_next_cnt;
      r_activate    <= w_next_activate;
      r_busy        <= (w_next_state != S_IDLE);
      r_timeout_err <= w_timeout_pulse;
      r_nak_start   <= (w_next_state == S_NAK_SEND);
      r_nak_data    <= (w_next_state == S_NAK_SEND) ? NAK_BYTE : 8'h00;
    end
  end

  tx_mux #(
    .N_SRC  (N_HANDLERS),
    .DATA_W (8),
    .SEL_W  (IDX_W)
  ) u_tx_mux (
    .i_sel        (r_idx),
    .i_force_idle (r_state != S_RUN),
    .i_start      (hnd_tx_start),
    .i_data       (hnd_tx_data),
    .o_start      (w_mux_start),
    .o_data       (w_mux_data)
  );

  // The mux is parked outside RUN and the NAK registers are zero inside it, so OR-merging is safe.
  assign tx_start     = w_mux_start | r_nak_start;
  assign tx_data      = w_mux_data | r_nak_data;
  assign hnd_activate = r_activate;
  assign hnd_rx_ready = r_activate & {N_HANDLERS{rx_ready}};
  assign busy         = r_busy;
  assign timeout_err  = r_timeout_err;

endmodule

// File: tb/tb_cmd_dispatcher.sv
// Self-checking bench for cmd_dispatcher: directed scenarios plus randomized traffic,
// all compared each cycle against a link-ownership reference model.
module tb_cmd_dispatcher;
  import cmd_pkg::*;

  localparam int N  = 4;
  localparam int TC = 100;

  logic            clk = 1'b0;
  logic            reset, rx_ready, tx_active, tx_done, tx_start, busy, timeout_err;
  logic [7:0]      rx_data, tx_data;
  logic [N-1:0]    hnd_activate, hnd_done, hnd_tx_start, hnd_rx_ready;
  logic [8*N-1:0]  hnd_tx_data;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Reference model: who owns the link and what the dispatcher is doing with it.
  bit m_run, m_rel, m_nakw, m_naks, m_tmo;
  int m_slot, m_quiet;

  bit         echo_on, echo_pend;
  logic [7:0] echo_byte;
  logic [7:0] echo_q[$];
  logic [7:0] uart_q[$];

  always #5 clk = ~clk;

  cmd_dispatcher #(.N_HANDLERS(N), .TIMEOUT_CYCLES(TC)) dut (
    .clk          (clk),
    .reset        (reset),
    .rx_ready     (rx_ready),
    .rx_data      (rx_data),
    .tx_active    (tx_active),
    .tx_done      (tx_done),
    .tx_start     (tx_start),
    .tx_data      (tx_data),
    .hnd_activate (hnd_activate),
    .hnd_done     (hnd_done),
    .hnd_tx_start (hnd_tx_start),
    .hnd_tx_data  (hnd_tx_data),
    .hnd_rx_ready (hnd_rx_ready),
    .busy         (busy),
    .timeout_err  (timeout_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step();
    int idx;
    if (reset) begin
      m_run = 0; m_rel = 0; m_nakw = 0; m_naks = 0; m_tmo = 0; m_slot = 0; m_quiet = 0;
      return;
    end
    m_tmo = 0;
    if (m_naks) begin
      m_naks = 0;
    end else if (m_nakw) begin
      if (!tx_active) begin m_nakw = 0; m_naks = 1; end
    end else if (m_rel) begin
      if (!hnd_done[m_slot] && !tx_active) m_rel = 0;
    end else if (m_run) begin
      if (hnd_done[m_slot] || m_quiet == TC - 1) begin
        m_run = 0; m_rel = 1;
      end else begin
        m_quiet = rx_ready ? 0 : m_quiet + 1;
        m_tmo   = (m_quiet == TC - 1);
      end
    end else if (rx_ready) begin
      idx = (int'(rx_data) - int'(OPC_BASE)) & 255;
      if (idx < N) begin m_run = 1; m_slot = idx; m_quiet = 0; end
      else m_nakw = 1;
    end
  endtask

  task automatic check_outputs();
    logic [N-1:0] e_act;
    logic         e_start;
    logic [7:0]   e_data;
    e_act   = m_run ? (N'(1) << m_slot) : '0;
    e_start = m_run ? hnd_tx_start[m_slot] : m_naks;
    e_data  = m_run ? hnd_tx_data[8*m_slot +: 8] : (m_naks ? NAK_BYTE : 8'h00);
    check("activate",    32'(hnd_activate), 32'(e_act));
    check("hnd_rx_rdy",  32'(hnd_rx_ready), 32'(e_act & {N{rx_ready}}));
    check("tx_start",    32'(tx_start),     32'(e_start));
    check("tx_data",     32'(tx_data),      32'(e_data));
    check("busy",        32'(busy),         32'(m_run | m_rel | m_nakw | m_naks));
    check("timeout_err", 32'(timeout_err),  32'(m_tmo));
  endtask

  // One clock: compare at the falling edge, advance the model at the rising edge,
  // then let stimulus change 1 time unit later.
  task automatic cycle();
    @(negedge clk);
    if (chk_en) check_outputs();
    if (echo_on && hnd_rx_ready[0]) begin
      echo_q.push_back(rx_data);
      echo_pend = 1'b1;
      echo_byte = rx_data;
    end
    if (tx_start) uart_q.push_back(tx_data);
    @(posedge clk);
    model_step();
    #1;
    if (echo_on) begin
      hnd_tx_start[0]  = echo_pend;
      hnd_tx_data[7:0] = echo_byte;
      echo_pend        = 1'b0;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_ready = 1'b1;
    rx_data  = b;
    cycle();
    rx_ready = 1'b0;
  endtask

  task automatic check_q_byte(input string tag, input int pos, input bit from_uart,
                              input logic [7:0] exp);
    logic [31:0] got;
    got = 32'hFFFF_FFFF;
    if (from_uart && pos < uart_q.size()) got = 32'(uart_q[pos]);
    if (!from_uart && pos < echo_q.size()) got = 32'(echo_q[pos]);
    check(tag, got, 32'(exp));
  endtask

  task automatic run_timeout(input bit with_rx, input int exp_cycle);
    int n = 1;
    send_byte(OPC_BASE + 8'd2);
    while (timeout_err !== 1'b1 && n < 300) begin
      rx_ready = with_rx && (n == 50);
      rx_data  = 8'($urandom);
      cycle();
      n++;
    end
    rx_ready = 1'b0;
    check("tmo_cycle", 32'(n), 32'(exp_cycle));
    cycle();
    check("tmo_act_drop",  32'(hnd_activate), 32'(0));
    check("tmo_pulse_end", 32'(timeout_err),  32'(0));
    repeat (3) cycle();
  endtask

  initial begin
    int odds;
    reset = 1'b1; rx_ready = 1'b0; rx_data = 8'h00; tx_active = 1'b0; tx_done = 1'b0;
    hnd_done = '0; hnd_tx_start = '0; hnd_tx_data = '0;
    echo_on = 1'b0; echo_pend = 1'b0; echo_byte = 8'h00;
    m_run = 0; m_rel = 0; m_nakw = 0; m_naks = 0; m_tmo = 0; m_slot = 0; m_quiet = 0;

    @(posedge clk);
    model_step();
    #1;
    chk_en = 1'b1;
    cycle();
    reset = 1'b0;
    check("rst_activate", 32'(hnd_activate), 32'(0));
    check("rst_busy",     32'(busy),         32'(0));
    check("rst_tx_start", 32'(tx_start),     32'(0));
    check("rst_tx_data",  32'(tx_data),      32'(0));
    check("rst_timeout",  32'(timeout_err),  32'(0));

    // Slot 0 echo handler: opcode 0x10 then payload 0x41, 0x55.
    echo_on = 1'b1;
    echo_q.delete();
    uart_q.delete();
    send_byte(8'h10);
    check("echo_act", 32'(hnd_activate), 32'(4'b0001));
    cycle();
    send_byte(8'h41);
    repeat (2) cycle();
    send_byte(8'h55);
    repeat (3) cycle();
    hnd_done[0] = 1'b1;
    cycle();
    check("echo_act_drop", 32'(hnd_activate), 32'(0));
    check("echo_rel_busy", 32'(busy), 32'(1));
    hnd_done[0] = 1'b0;
    repeat (2) cycle();
    check("echo_idle", 32'(busy), 32'(0));
    echo_on = 1'b0;
    hnd_tx_start = '0;
    check("echo_seen_n", 32'(echo_q.size()), 32'(2));
    check_q_byte("echo_seen_0", 0, 1'b0, 8'h41);
    check_q_byte("echo_seen_1", 1, 1'b0, 8'h55);
    check("uart_sent_n", 32'(uart_q.size()), 32'(2));
    check_q_byte("uart_sent_0", 0, 1'b1, 8'h41);
    check_q_byte("uart_sent_1", 1, 1'b1, 8'h55);

    // Out-of-range opcode: NAK two cycles after the opcode.
    uart_q.delete();
    send_byte(8'h20);
    cycle();
    check("nak_start",     32'(tx_start),     32'(1));
    check("nak_data",      32'(tx_data),      32'(NAK_BYTE));
    check("nak_no_act",    32'(hnd_activate), 32'(0));
    cycle();
    check("nak_pulse_end", 32'(tx_start),     32'(0));
    repeat (2) cycle();
    check("nak_idle",      32'(busy),         32'(0));
    check("nak_count",     32'(uart_q.size()), 32'(1));

    // Wrapped opcode 0x0F while the transmitter is busy: NAK waits for it.
    uart_q.delete();
    tx_active = 1'b1;
    send_byte(8'h0F);
    repeat (3) cycle();
    check("wrap_wait_n",    32'(uart_q.size()), 32'(0));
    check("wrap_wait_busy", 32'(busy), 32'(1));
    tx_active = 1'b0;
    repeat (4) cycle();
    check("wrap_nak_n", 32'(uart_q.size()), 32'(1));
    check_q_byte("wrap_nak_byte", 0, 1'b1, NAK_BYTE);
    check("wrap_idle", 32'(busy), 32'(0));

    // Inactivity timeout on slot 2, without and with an RX byte in cycle 50.
    run_timeout(1'b0, 100);
    run_timeout(1'b1, 150);

    // Slot 1 owns TX while slot 3 keeps requesting.
    send_byte(OPC_BASE + 8'd1);
    for (int k = 0; k < 20; k++) begin
      hnd_tx_start = {1'b1, 1'b0, 1'($urandom), 1'b0};
      hnd_tx_data  = $urandom;
      rx_ready     = 1'($urandom);
      rx_data      = 8'($urandom);
      #1;
      check("mux_s1_start", 32'(tx_start), 32'(hnd_tx_start[1]));
      check("mux_s1_data",  32'(tx_data),  32'(hnd_tx_data[15:8]));
      check("rxr_s3_zero",  32'(hnd_rx_ready[3]), 32'(0));
      cycle();
    end

    // Reset while slot 1 is running, then a fresh opcode.
    hnd_tx_start = 4'b0010;
    rx_ready     = 1'b0;
    reset        = 1'b1;
    cycle();
    reset = 1'b0;
    check("rstrun_act",   32'(hnd_activate), 32'(0));
    check("rstrun_busy",  32'(busy),         32'(0));
    check("rstrun_start", 32'(tx_start),     32'(0));
    hnd_tx_start = '0;
    send_byte(OPC_BASE + 8'd1);
    check("reopen_act", 32'(hnd_activate), 32'(4'b0010));
    hnd_done[1] = 1'b1;
    cycle();
    hnd_done = '0;
    repeat (3) cycle();

    // Randomized traffic with varying RX density.
    for (int blk = 0; blk < 6; blk++) begin
      odds = (blk % 3 == 0) ? 3 : ((blk % 3 == 1) ? 30 : 400);
      for (int c = 0; c < 400; c++) begin
        reset        = ($urandom_range(0, 499) == 0);
        rx_ready     = ($urandom_range(0, odds) == 0);
        rx_data      = ($urandom_range(0, 2) == 0) ? 8'($urandom)
                                                  : 8'(8'h0E + 8'($urandom_range(0, 7)));
        tx_active    = ($urandom_range(0, 3) == 0);
        tx_done      = 1'($urandom);
        hnd_done     = ($urandom_range(0, 149) == 0) ? 4'($urandom) : (hnd_done & 4'($urandom));
        hnd_tx_start = 4'($urandom);
        hnd_tx_data  = $urandom;
        cycle();
      end
    end

    reset = 1'b1;
    cycle();
    reset = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
